// File: rtl/uart_pkg.sv
// Shared constants for the UART receive path: frame geometry, sample points and FSM state codes.
package uart_pkg;

  localparam int OVERSAMPLE = 16;
  localparam int DATA_W     = 8;

  localparam logic [3:0] SAMPLE_A = 4'd7;
  localparam logic [3:0] SAMPLE_B = 4'd8;
  localparam logic [3:0] SAMPLE_C = 4'd9;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_START  = 3'd1;
  localparam state_t ST_DATA   = 3'd2;
  localparam state_t ST_PARITY = 3'd3;
  localparam state_t ST_STOP   = 3'd4;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_tick_gen.sv
// Sample-tick divider: one tick every max(divisor,1) clocks; a new divisor takes effect at the next wrap.
module uart_tick_gen (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic [15:0] divisor,
  output logic        tick
);

  logic [15:0] cnt_reg;
  logic [15:0] cnt_next;
  logic [15:0] div_reg;
  logic [15:0] div_next;
  logic [15:0] terminal;

  // 0 and 1 both collapse to a terminal count of 0, i.e. a tick every cycle
  assign terminal = (div_reg <= 16'd1) ? 16'd0 : div_reg - 16'd1;
  assign tick     = (cnt_reg == terminal);

  always_comb begin
    cnt_next = cnt_reg + 16'd1;
    div_next = div_reg;
    if (clear) begin
      cnt_next = 16'd0;
    end else if (tick) begin
      cnt_next = 16'd0;
      div_next = divisor;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= 16'd0;
      div_reg <= 16'd0;
    end else begin
      cnt_reg <= cnt_next;
      div_reg <= div_next;
    end
  end

endmodule

// File: rtl/uart_rx_sampler.sv
// Oversampling UART receiver with 2-of-3 majority bit decisions.
// Define UART_RX_PARITY_EN to add an even-parity bit between the data bits and the stop bit.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE  = uart_pkg::OVERSAMPLE,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [15:0]       divisor,
  input  logic              serial_in,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              frame_err,
  output logic              parity_err,
  output logic              rx_busy
);

  localparam logic [3:0] SAMPLE_LAST = 4'(OVERSAMPLE - 1);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic [SYNC_STAGES:0]   sync_d;
  logic                   line;
  logic                   line_prev_reg;

  assign sync_d[0] = serial_in;
  for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
    assign sync_d[gi+1] = sync_reg[gi];
  end
  assign line = sync_reg[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg      <= '1;
      line_prev_reg <= 1'b1;
    end else begin
      sync_reg      <= sync_d[SYNC_STAGES-1:0];
      line_prev_reg <= line;
    end
  end

  logic tick;
  logic tick_clear;

  uart_tick_gen u_tick_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (tick_clear),
    .divisor (divisor),
    .tick    (tick)
  );

  state_t            state_reg, state_next;
  logic [3:0]        sample_cnt_reg, sample_cnt_next;
  logic [2:0]        bit_cnt_reg, bit_cnt_next;
  logic [DATA_W-1:0] shift_reg, shift_next;
  logic              s7_reg, s7_next;
  logic              s8_reg, s8_next;
  logic [DATA_W-1:0] rx_data_reg, rx_data_next;
  logic              rx_valid_reg, rx_valid_next;
  logic              frame_err_reg, frame_err_next;
  logic              parity_err_reg, parity_err_next;
  logic              maj;

`ifdef UART_RX_PARITY_EN
  logic              par_bad_reg, par_bad_next;
  localparam state_t AFTER_DATA = ST_PARITY;
`else
  localparam state_t AFTER_DATA = ST_STOP;
`endif

  // the third vote is the live line at count 9, so the decision lands on that tick
  assign maj = majority3(s7_reg, s8_reg, line);

  always_comb begin
    state_next      = state_reg;
    sample_cnt_next = sample_cnt_reg;
    bit_cnt_next    = bit_cnt_reg;
    shift_next      = shift_reg;
    s7_next         = s7_reg;
    s8_next         = s8_reg;
    rx_data_next    = rx_data_reg;
    rx_valid_next   = 1'b0;
    frame_err_next  = 1'b0;
    parity_err_next = 1'b0;
    tick_clear      = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_next    = par_bad_reg;
`endif
    if (state_reg == ST_IDLE) begin
      if (line_prev_reg && !line) begin
        tick_clear      = 1'b1;
        sample_cnt_next = 4'd0;
        state_next      = ST_START;
      end
    end else if (tick) begin
      sample_cnt_next = sample_cnt_reg + 4'd1;
      if (sample_cnt_reg == SAMPLE_A) s7_next = line;
      if (sample_cnt_reg == SAMPLE_B) s8_next = line;
      case (state_reg)
        ST_START: begin
          if (sample_cnt_reg == SAMPLE_C && maj) begin
            state_next = ST_IDLE;
          end else if (sample_cnt_reg == SAMPLE_LAST) begin
            state_next   = ST_DATA;
            bit_cnt_next = 3'd0;
          end
        end
        ST_DATA: begin
          if (sample_cnt_reg == SAMPLE_C) shift_next = {maj, shift_reg[DATA_W-1:1]};
          if (sample_cnt_reg == SAMPLE_LAST) begin
            bit_cnt_next = bit_cnt_reg + 3'd1;
            if (bit_cnt_reg == 3'd7) state_next = AFTER_DATA;
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (sample_cnt_reg == SAMPLE_C) par_bad_next = maj ^ (^shift_reg);
          if (sample_cnt_reg == SAMPLE_LAST) state_next = ST_STOP;
        end
`endif
        ST_STOP: begin
          if (sample_cnt_reg == SAMPLE_C) begin
            rx_data_next   = shift_reg;
            rx_valid_next  = maj;
            frame_err_next = !maj;
`ifdef UART_RX_PARITY_EN
            parity_err_next = maj & par_bad_reg;
`endif
            state_next     = ST_IDLE;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      sample_cnt_reg <= 4'd0;
      bit_cnt_reg    <= 3'd0;
      shift_reg      <= '0;
      s7_reg         <= 1'b1;
      s8_reg         <= 1'b1;
      rx_data_reg    <= '0;
      rx_valid_reg   <= 1'b0;
      frame_err_reg  <= 1'b0;
      parity_err_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      sample_cnt_reg <= sample_cnt_next;
      bit_cnt_reg    <= bit_cnt_next;
      shift_reg      <= shift_next;
      s7_reg         <= s7_next;
      s8_reg         <= s8_next;
      rx_data_reg    <= rx_data_next;
      rx_valid_reg   <= rx_valid_next;
      frame_err_reg  <= frame_err_next;
      parity_err_reg <= parity_err_next;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) par_bad_reg <= 1'b0;
    else        par_bad_reg <= par_bad_next;
  end
`endif

  assign rx_data    = rx_data_reg;
  assign rx_valid   = rx_valid_reg;
  assign frame_err  = frame_err_reg;
  assign parity_err = parity_err_reg;
  assign rx_busy    = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Bench for uart_rx_sampler: table of frames plus hand sequences, checked against an expectation queue.
module tb_uart_rx_sampler;

  localparam int DIV = 4;
  localparam int BIT = 16 * DIV;
`ifdef UART_RX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] divisor = 16'(DIV);
  logic        serial_in = 1'b1;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        frame_err;
  logic        parity_err;
  logic        rx_busy;

  always #5 clk = ~clk;

  uart_rx_sampler dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .divisor    (divisor),
    .serial_in  (serial_in),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .rx_busy    (rx_busy)
  );

  typedef struct packed {
    logic       valid;
    logic       ferr;
    logic       perr;
    logic [7:0] data;
  } exp_t;

  typedef struct {
    logic [7:0] data;
    logic       stop_bit;
    logic       par_flip;
  } vec_t;

  int   n_vec = 0;
  int   n_err = 0;
  int   pulse_cnt = 0;
  int   cyc = 0;
  int   valid_t[$];
  exp_t exp_q[$];
  exp_t got_e;
  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every output pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (rst_n && (rx_valid || frame_err || parity_err)) begin
      pulse_cnt++;
      if (rx_valid) valid_t.push_back(cyc);
      check("valid_ferr_exclusive", {31'd0, rx_valid & frame_err}, 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", exp_q.size(), 32'd1);
      end else begin
        got_e = exp_q.pop_front();
        check("rx_valid", {31'd0, rx_valid}, {31'd0, got_e.valid});
        check("frame_err", {31'd0, frame_err}, {31'd0, got_e.ferr});
        check("parity_err", {31'd0, parity_err}, {31'd0, got_e.perr});
        check("rx_data", {24'd0, rx_data}, {24'd0, got_e.data});
        $display("frame data=%02h valid=%0b ferr=%0b perr=%0b at cycle %0d",
                 rx_data, rx_valid, frame_err, parity_err, cyc);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    serial_in = b;
    idle(BIT);
  endtask

  task automatic send_frame(input logic [7:0] data, input logic stop_bit, input logic par_flip);
    exp_t e;
    e.valid = stop_bit;
    e.ferr  = ~stop_bit;
`ifdef UART_RX_PARITY_EN
    e.perr  = par_flip & stop_bit;
`else
    e.perr  = 1'b0;
`endif
    e.data  = data;
    exp_q.push_back(e);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(data[i]);
`ifdef UART_RX_PARITY_EN
    send_bit((^data) ^ par_flip);
`endif
    send_bit(stop_bit);
  endtask

  int p0;
  int n0;
  logic [7:0] partial;

  initial begin
    vecs[0] = '{8'hA5, 1'b1, 1'b0};
    vecs[1] = '{8'hC3, 1'b1, 1'b0};
    vecs[2] = '{8'h01, 1'b1, 1'b0};
    vecs[3] = '{8'h80, 1'b1, 1'b0};
    vecs[4] = '{8'h6E, 1'b1, 1'b0};

    // Reset state
    idle(5);
    check("reset_rx_data", {24'd0, rx_data}, 32'd0);
    check("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("reset_frame_err", {31'd0, frame_err}, 32'd0);
    check("reset_parity_err", {31'd0, parity_err}, 32'd0);
    check("reset_rx_busy", {31'd0, rx_busy}, 32'd0);
    rst_n = 1'b1;
    idle(10);

    // Table-driven good frames
    for (int i = 0; i < 5; i++) begin
      send_frame(vecs[i].data, vecs[i].stop_bit, vecs[i].par_flip);
      serial_in = 1'b1;
      idle(BIT);
      check("rx_data_hold", {24'd0, rx_data}, {24'd0, vecs[i].data});
      check("busy_after_frame", {31'd0, rx_busy}, 32'd0);
    end

    // Glitch of 3 ticks in idle
    p0 = pulse_cnt;
    serial_in = 1'b0;
    idle(10);
    check("glitch_busy_high", {31'd0, rx_busy}, 32'd1);
    idle(2);
    serial_in = 1'b1;
    idle(2 * BIT);
    check("glitch_busy_low", {31'd0, rx_busy}, 32'd0);
    check("glitch_no_pulse", pulse_cnt, p0);

    // Framing error followed by a 40-bit break
    p0 = pulse_cnt;
    send_frame(8'h3C, 1'b0, 1'b0);
    idle(40 * BIT);
    check("break_single_pulse", pulse_cnt - p0, 32'd1);
    check("ferr_rx_data", {24'd0, rx_data}, 32'h3C);
    check("break_busy_low", {31'd0, rx_busy}, 32'd0);
    serial_in = 1'b1;
    idle(2 * BIT);

    // Back-to-back frames with no idle gap
    n0 = valid_t.size();
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    serial_in = 1'b1;
    idle(BIT);
    check("b2b_valid_count", valid_t.size() - n0, 32'd2);
    if (valid_t.size() >= n0 + 2)
      check("b2b_spacing", valid_t[n0+1] - valid_t[n0], FRAME_BITS * BIT);

    // Reset during bit 4 of 0x5A
    p0 = pulse_cnt;
    partial = 8'h5A;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(partial[i]);
    serial_in = partial[4];
    idle(BIT / 2);
    rst_n = 1'b0;
    idle(3);
    check("midreset_rx_data", {24'd0, rx_data}, 32'd0);
    check("midreset_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("midreset_rx_busy", {31'd0, rx_busy}, 32'd0);
    idle(BIT / 2);
    rst_n = 1'b1;
    serial_in = 1'b1;
    idle(2 * BIT);
    check("midreset_no_pulse", pulse_cnt, p0);
    send_frame(8'h81, 1'b1, 1'b0);
    serial_in = 1'b1;
    idle(BIT);
    check("after_reset_rx_data", {24'd0, rx_data}, 32'h81);

`ifdef UART_RX_PARITY_EN
    // Wrong parity still delivers the byte
    send_frame(8'h07, 1'b1, 1'b1);
    serial_in = 1'b1;
    idle(BIT);
    check("parity_rx_data", {24'd0, rx_data}, 32'h07);
`endif

    idle(BIT);
    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
